// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
// rtc_bus_pkg -- port ids, FSM encoding and transaction type for the RTC bus
// Revision: 1.0
// ============================================================================
package rtc_bus_pkg;

  localparam logic [7:0] PORT_ADDR_DEFAULT  = 8'h01;
  localparam logic [7:0] PORT_WDATA_DEFAULT = 8'h02;
  localparam logic [7:0] PORT_RCMD_DEFAULT  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4
  } rtc_state_t;

  typedef enum logic {
    TXN_WR = 1'b0,
    TXN_RD = 1'b1
  } rtc_txn_t;

  // Fixed phase sequence of a bus transaction; GAP2 returns to IDLE.
  function automatic rtc_state_t next_phase(input rtc_state_t s);
    rtc_state_t n;
    case (s)
      ST_ADDR: n = ST_GAP1;
      ST_GAP1: n = ST_DATA;
      ST_DATA: n = ST_GAP2;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
// rtc_phase_timer -- loadable down-counter, expire pulses on a phase's last cycle
// Revision: 1.0
// ============================================================================
module rtc_phase_timer #(
  parameter int unsigned T_PULSE = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned   CW       = (T_PULSE > 1) ? $clog2(T_PULSE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(T_PULSE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// rtc_bus_driver -- turns PicoBlaze port writes into RTC multiplexed AD bus cycles
// Revision: 1.0
// ============================================================================
module rtc_bus_driver
  import rtc_bus_pkg::*;
#(
  parameter logic [7:0]  PORT_ADDR  = PORT_ADDR_DEFAULT,
  parameter logic [7:0]  PORT_WDATA = PORT_WDATA_DEFAULT,
  parameter logic [7:0]  PORT_RCMD  = PORT_RCMD_DEFAULT,
  parameter int unsigned T_PULSE    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] datao_rtc_port,
  output logic [7:0] donew_port,
  output logic [7:0] doner_port,
  output logic       busy
);

  rtc_state_t state;
  rtc_state_t state_next;
  rtc_txn_t   txn;

  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic       donew;
  logic       doner;

  logic cmd_ok;
  logic hit_addr;
  logic hit_wdata;
  logic hit_rcmd;
  logic start;
  logic expire;
  logic timer_load;
  logic timer_en;
  logic data_last;
  logic gap2_last;

  logic [7:0] ad_out_next;
  logic       ad_oe_next;
  logic       a_d_next;
  logic       cs_n_next;
  logic       wr_n_next;
  logic       rd_n_next;

  assign cmd_ok    = write_strobe && (state == ST_IDLE);
  assign hit_addr  = cmd_ok && (port_id == PORT_ADDR);
  assign hit_wdata = cmd_ok && (port_id == PORT_WDATA);
  assign hit_rcmd  = cmd_ok && (port_id == PORT_RCMD);
  assign start     = hit_wdata || hit_rcmd;

  assign timer_en   = (state != ST_IDLE);
  assign timer_load = start || (expire && (state != ST_GAP2));
  assign data_last  = (state == ST_DATA) && expire;
  assign gap2_last  = (state == ST_GAP2) && expire;

  rtc_phase_timer #(
    .T_PULSE (T_PULSE)
  ) u_phase_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .enable (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are decoded from the next state so the registered pins change
  // on the same edge as the state register.
  always_comb begin
    state_next  = state;
    ad_out_next = ad_out;
    ad_oe_next  = 1'b0;
    a_d_next    = 1'b1;
    cs_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    rd_n_next   = 1'b1;

    if (state == ST_IDLE) begin
      if (start) begin
        state_next = ST_ADDR;
      end
    end else if (expire) begin
      state_next = next_phase(state);
    end

    case (state_next)
      ST_ADDR: begin
        a_d_next    = 1'b0;
        cs_n_next   = 1'b0;
        wr_n_next   = 1'b0;
        ad_oe_next  = 1'b1;
        ad_out_next = addr_reg;
      end
      ST_GAP1: begin
        a_d_next = 1'b0;
      end
      ST_DATA: begin
        cs_n_next = 1'b0;
        if (txn == TXN_WR) begin
          wr_n_next   = 1'b0;
          ad_oe_next  = 1'b1;
          ad_out_next = wdata_reg;
        end else begin
          rd_n_next = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ad_out         <= 8'h00;
      ad_oe          <= 1'b0;
      a_d            <= 1'b1;
      cs_n           <= 1'b1;
      wr_n           <= 1'b1;
      rd_n           <= 1'b1;
      busy           <= 1'b0;
      txn            <= TXN_WR;
      addr_reg       <= 8'h00;
      wdata_reg      <= 8'h00;
      datao_rtc_port <= 8'h00;
      donew          <= 1'b0;
      doner          <= 1'b0;
    end else begin
      ad_out <= ad_out_next;
      ad_oe  <= ad_oe_next;
      a_d    <= a_d_next;
      cs_n   <= cs_n_next;
      wr_n   <= wr_n_next;
      rd_n   <= rd_n_next;
      busy   <= (state_next != ST_IDLE);

      if (hit_addr) begin
        addr_reg <= out_port;
      end
      if (hit_wdata) begin
        wdata_reg <= out_port;
      end
      if (hit_wdata) begin
        txn <= TXN_WR;
      end else if (hit_rcmd) begin
        txn <= TXN_RD;
      end

      if (data_last && (txn == TXN_RD)) begin
        datao_rtc_port <= ad_in;
      end

      if (hit_addr || start) begin
        donew <= 1'b0;
        doner <= 1'b0;
      end else if (gap2_last) begin
        if (txn == TXN_WR) begin
          donew <= 1'b1;
        end else begin
          doner <= 1'b1;
        end
      end
    end
  end

  assign donew_port = {7'b0000000, donew};
  assign doner_port = {7'b0000000, doner};

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// tb_rtc_bus_driver -- vector table plus bus-monitor scoreboard for rtc_bus_driver
// Revision: 1.0
// ============================================================================
module tb_rtc_bus_driver;

  localparam int         T       = 8;
  localparam logic [7:0] P_ADDR  = 8'h01;
  localparam logic [7:0] P_WDATA = 8'h02;
  localparam logic [7:0] P_RCMD  = 8'h03;

  logic       clock        = 1'b0;
  logic       reset        = 1'b1;
  logic [7:0] port_id      = 8'h00;
  logic [7:0] out_port     = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       a_d;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] datao_rtc_port;
  logic [7:0] donew_port;
  logic [7:0] doner_port;
  logic       busy;

  logic [7:0] rtc_byte = 8'h00;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t sb_q[$];
  txn_t vecs[5];
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  // RTC model: drives its register byte while the read strobe is low.
  assign ad_in = (!rd_n) ? rtc_byte : 8'h00;

  rtc_bus_driver #(
    .PORT_ADDR  (P_ADDR),
    .PORT_WDATA (P_WDATA),
    .PORT_RCMD  (P_RCMD),
    .T_PULSE    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .ad_in          (ad_in),
    .ad_out         (ad_out),
    .ad_oe          (ad_oe),
    .a_d            (a_d),
    .cs_n           (cs_n),
    .wr_n           (wr_n),
    .rd_n           (rd_n),
    .datao_rtc_port (datao_rtc_port),
    .donew_port     (donew_port),
    .doner_port     (doner_port),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Expected pin state for cycle c (1-based) of a transaction.
  function automatic int cycle_bad(input int c, input txn_t e);
    bit ok;
    if (c <= T)
      ok = (cs_n === 1'b0) && (a_d === 1'b0) && (wr_n === 1'b0) && (rd_n === 1'b1) &&
           (ad_oe === 1'b1) && (ad_out === e.addr);
    else if (c <= 2*T)
      ok = (cs_n === 1'b1) && (a_d === 1'b0) && (wr_n === 1'b1) && (rd_n === 1'b1) &&
           (ad_oe === 1'b0) && (ad_out === e.addr);
    else if (c <= 3*T) begin
      if (e.rd)
        ok = (cs_n === 1'b0) && (a_d === 1'b1) && (wr_n === 1'b1) && (rd_n === 1'b0) &&
             (ad_oe === 1'b0) && (ad_out === e.addr);
      else
        ok = (cs_n === 1'b0) && (a_d === 1'b1) && (wr_n === 1'b0) && (rd_n === 1'b1) &&
             (ad_oe === 1'b1) && (ad_out === e.data);
    end else
      ok = (cs_n === 1'b1) && (a_d === 1'b1) && (wr_n === 1'b1) && (rd_n === 1'b1) &&
           (ad_oe === 1'b0) && (ad_out === (e.rd ? e.addr : e.data));
    return ok ? 0 : 1;
  endfunction

  bit   mon_active = 1'b0;
  bit   mon_valid  = 1'b0;
  int   mon_cyc    = 0;
  int   mon_bad    = 0;
  txn_t mon_exp;

  always @(negedge clock) begin
    if (reset) begin
      if (mon_active && mon_valid) sb_q.delete(0);
      mon_active = 1'b0;
    end else if (busy) begin
      if (!mon_active) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_bad    = 0;
        mon_valid  = (sb_q.size() > 0);
        if (mon_valid) mon_exp = sb_q[0];
        else chk("unexpected_txn", 32'd0, 32'd1);
      end
      mon_cyc++;
      if (mon_valid) mon_bad += cycle_bad(mon_cyc, mon_exp);
    end else if (mon_active) begin
      mon_active = 1'b0;
      if (mon_valid) begin
        sb_q.delete(0);
        chk("txn_length", mon_cyc, 4*T);
        chk("txn_bad_bus_cycles", mon_bad, 0);
        chk("txn_donew", donew_port, mon_exp.rd ? 32'd0 : 32'd1);
        chk("txn_doner", doner_port, mon_exp.rd ? 32'd1 : 32'd0);
        if (mon_exp.rd) chk("txn_read_data", datao_rtc_port, mon_exp.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
    port_id      = P_RCMD;
    out_port     = 8'hA5;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      tick(1);
      cycles++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input txn_t v);
    int n;
    cmd(P_ADDR, v.addr);
    chk("addr_cmd_busy", busy, 0);
    chk("addr_cmd_cs_n", cs_n, 1);
    chk("addr_cmd_donew", donew_port, 0);
    chk("addr_cmd_doner", doner_port, 0);
    if (v.rd) rtc_byte = v.data;
    sb_q.push_back(v);
    cmd(v.rd ? P_RCMD : P_WDATA, v.data);
    chk("start_busy", busy, 1);
    chk("start_addr_phase", {cs_n, a_d}, 2'b00);
    wait_idle(8*T, n);
    chk("busy_cycles", n, 4*T);
  endtask

  initial begin
    int n;
    vecs[0] = '{rd: 1'b0, addr: 8'h21, data: 8'h45};
    vecs[1] = '{rd: 1'b1, addr: 8'h42, data: 8'h59};
    vecs[2] = '{rd: 1'b0, addr: 8'hFF, data: 8'h00};
    vecs[3] = '{rd: 1'b1, addr: 8'h00, data: 8'hA5};
    vecs[4] = '{rd: 1'b0, addr: 8'h7E, data: 8'h81};

    tick(3);
    chk("rst_ad_out", ad_out, 8'h00);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_a_d", a_d, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_datao", datao_rtc_port, 8'h00);
    chk("rst_donew", donew_port, 8'h00);
    chk("rst_doner", doner_port, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Commands while busy must be ignored, including a new address.
    cmd(P_ADDR, 8'h21);
    sb_q.push_back('{rd: 1'b0, addr: 8'h21, data: 8'h45});
    cmd(P_WDATA, 8'h45);
    tick(3);
    cmd(P_WDATA, 8'h11);
    cmd(P_ADDR, 8'h99);
    cmd(P_RCMD, 8'h00);
    wait_idle(8*T, n);
    chk("lockout_remaining_cycles", n, 4*T - 6);

    // Start in the very cycle done rises.
    sb_q.push_back('{rd: 1'b0, addr: 8'h21, data: 8'h3C});
    cmd(P_WDATA, 8'h3C);
    chk("b2b_donew_cleared", donew_port, 8'h00);
    chk("b2b_busy", busy, 1);
    wait_idle(8*T, n);
    chk("b2b_cycles", n, 4*T);
    tick(10);
    chk("sticky_donew", donew_port, 8'h01);
    chk("sticky_idle", busy, 0);

    // Reset during the data phase.
    cmd(P_ADDR, 8'h5A);
    sb_q.push_back('{rd: 1'b0, addr: 8'h5A, data: 8'hC3});
    cmd(P_WDATA, 8'hC3);
    tick(2*T + 2);
    chk("pre_reset_data_phase", {cs_n, wr_n, a_d}, 3'b001);
    reset = 1'b1;
    tick(1);
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_wr_n", wr_n, 1);
    chk("midrst_ad_oe", ad_oe, 0);
    chk("midrst_a_d", a_d, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_donew", donew_port, 8'h00);
    reset = 1'b0;
    tick(1);
    run_txn('{rd: 1'b0, addr: 8'h66, data: 8'h99});

    // Done-flag clearing and unmatched port ids.
    run_txn('{rd: 1'b1, addr: 8'h10, data: 8'h77});
    cmd(8'h07, 8'h55);
    chk("badport_doner", doner_port, 8'h01);
    chk("badport_busy", busy, 0);
    chk("badport_cs_n", cs_n, 1);
    cmd(P_ADDR, 8'h00);
    chk("addr_clears_doner", doner_port, 8'h00);
    cmd(8'h07, 8'h66);
    sb_q.push_back('{rd: 1'b0, addr: 8'h00, data: 8'h3C});
    cmd(P_WDATA, 8'h3C);
    wait_idle(8*T, n);
    chk("final_cycles", n, 4*T);
    tick(2);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
